// File: rtl/spmv_feeder_if.sv
// Bus bundle between spmv_feeder and its pointer/nonzero/vector memories and the SpMV core.
// Signal names are from the feeder's point of view.
interface spmv_feeder_if #(
  parameter int DW   = 16,
  parameter int NROW = 16,
  parameter int CW   = 4
);
  logic [4:0]            o_ptr_addr;
  logic [7:0]            i_ptr_data;
  logic [7:0]            o_nz_addr;
  logic [DW-1:0]         i_nz_val;
  logic [CW-1:0]         i_nz_col;
  logic [CW-1:0]         o_vec_addr;
  logic [DW-1:0]         i_vec_data;
  logic [2:0]            i_core_state;
  logic                  o_core_start;
  logic [DW-1:0]         o_read_data_A;
  logic [DW-1:0]         o_read_data_B;
  logic [7:0]            o_count;
  logic [8*(NROW+1)-1:0] o_row_ptr;

  modport master (
    output o_ptr_addr,
    input  i_ptr_data,
    output o_nz_addr,
    input  i_nz_val,
    input  i_nz_col,
    output o_vec_addr,
    input  i_vec_data,
    input  i_core_state,
    output o_core_start,
    output o_read_data_A,
    output o_read_data_B,
    output o_count,
    output o_row_ptr
  );

  modport slave (
    input  o_ptr_addr,
    output i_ptr_data,
    input  o_nz_addr,
    output i_nz_val,
    output i_nz_col,
    input  o_vec_addr,
    output i_vec_data,
    output i_core_state,
    input  o_core_start,
    input  o_read_data_A,
    input  o_read_data_B,
    input  o_count,
    input  o_row_ptr
  );
endinterface

// File: rtl/spmv_feeder.sv
// Operand feeder for the SpMV core: loads the CSR row pointers, prefetches value/column/vector
// for each nonzero in step with the core pipeline, and restarts the core across batch stops.
module spmv_feeder #(
  parameter int DW   = 16,
  parameter int NROW = 16,
  parameter int CW   = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  spmv_feeder_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PTR, S_PRE0, S_PRE1, S_PRE2, S_KICK, S_RUN, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_LOAD  = 3'd1,
    C_MUL   = 3'd2,
    C_ADD   = 3'd3,
    C_WRITE = 3'd4
  } core_t;

  localparam logic [4:0] LP_PTR_LAST = 5'(NROW);
  localparam logic [4:0] LP_PTR_END  = 5'(NROW + 1);

  state_t                r_state, w_next;
  logic [4:0]            r_pidx, r_ptr_hold, w_ptr_addr;
  logic [8:0]            r_cnt, w_cnt_inc, w_nnz;
  logic [7:0]            r_nz_hold, w_nz_addr;
  logic [CW-1:0]         r_vec_hold, w_vec_addr;
  logic [DW-1:0]         r_val, r_A, r_B;
  logic [8*(NROW+1)-1:0] r_row_ptr;
  logic                  w_core_start;

  assign w_nnz     = {1'b0, r_row_ptr[8*NROW +: 8]};
  assign w_cnt_inc = r_cnt + 9'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Addresses are combinational while a state drives them and otherwise replay the hold register.
  always_comb begin
    w_next       = r_state;
    w_ptr_addr   = r_ptr_hold;
    w_nz_addr    = r_nz_hold;
    w_vec_addr   = r_vec_hold;
    w_core_start = 1'b0;
    o_busy       = (r_state != S_IDLE);
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_PTR;
      S_PTR: begin
        if (r_pidx <= LP_PTR_LAST) w_ptr_addr = r_pidx;
        if (r_pidx == LP_PTR_END)
          w_next = (io_bus.i_ptr_data == 8'd0) ? S_DONE : S_PRE0;
      end
      S_PRE0: begin
        w_nz_addr = r_cnt[7:0];
        w_next    = S_PRE1;
      end
      S_PRE1: begin
        w_vec_addr = io_bus.i_nz_col;
        w_next     = S_PRE2;
      end
      S_PRE2: w_next = S_KICK;
      S_KICK: begin
        w_core_start = 1'b1;
        w_next       = S_RUN;
      end
      S_RUN: begin
        case (io_bus.i_core_state)
          C_MUL:   w_nz_addr  = w_cnt_inc[7:0];
          C_ADD:   w_vec_addr = io_bus.i_nz_col;
          C_IDLE:  w_next     = (r_cnt > w_nnz) ? S_DONE : S_KICK;
          default: ;
        endcase
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pidx     <= '0;
      r_ptr_hold <= '0;
      r_nz_hold  <= '0;
      r_vec_hold <= '0;
      r_cnt      <= '0;
      r_val      <= '0;
      r_A        <= '0;
      r_B        <= '0;
      r_row_ptr  <= '0;
    end else begin
      r_ptr_hold <= w_ptr_addr;
      r_nz_hold  <= w_nz_addr;
      r_vec_hold <= w_vec_addr;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_cnt     <= '0;
          r_row_ptr <= '0;
          r_pidx    <= '0;
        end
        S_PTR: begin
          // Memory data for address k arrives while r_pidx == k+1.
          for (int unsigned k = 0; k <= NROW; k++)
            if (r_pidx == 5'(k + 1)) r_row_ptr[8*k +: 8] <= io_bus.i_ptr_data;
          r_pidx <= r_pidx + 5'd1;
        end
        S_PRE1: r_val <= io_bus.i_nz_val;
        S_PRE2: begin
          r_A <= r_val;
          r_B <= io_bus.i_vec_data;
        end
        S_RUN: begin
          if (io_bus.i_core_state == C_ADD) r_val <= io_bus.i_nz_val;
          // Operands advance only on the edge leaving WRITE, so they are settled before LOAD.
          if (io_bus.i_core_state == C_WRITE) begin
            if (w_cnt_inc >= w_nnz) begin
              r_A <= '0;
              r_B <= '0;
            end else begin
              r_A <= r_val;
              r_B <= io_bus.i_vec_data;
            end
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.o_ptr_addr    = w_ptr_addr;
  assign io_bus.o_nz_addr     = w_nz_addr;
  assign io_bus.o_vec_addr    = w_vec_addr;
  assign io_bus.o_core_start  = w_core_start;
  assign io_bus.o_read_data_A = r_A;
  assign io_bus.o_read_data_B = r_B;
  assign io_bus.o_count       = r_cnt[7:0];
  assign io_bus.o_row_ptr     = r_row_ptr;

endmodule

// File: tb/tb_spmv_feeder.sv
// Bench for spmv_feeder: sync-read memories, a behavioural SpMV core that stops at finish or on
// 16-element boundaries, and a reference model of operand order and job timing.
`timescale 1ns/1ps
module tb_spmv_feeder;
  localparam int DW   = 16;
  localparam int NROW = 16;
  localparam int CW   = 4;
  localparam int LIM  = 3000;

  typedef logic [135:0] w_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  spmv_feeder_if #(.DW(DW), .NROW(NROW), .CW(CW)) bus();

  spmv_feeder #(.DW(DW), .NROW(NROW), .CW(CW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  // Memories with one cycle read latency
  logic [7:0]    ptr_mem [0:31];
  logic [DW-1:0] nzv     [0:255];
  logic [CW-1:0] nzc     [0:255];
  logic [DW-1:0] vec     [0:15];
  logic [7:0]    ptr_q;
  logic [DW-1:0] nzv_q, vec_q;
  logic [CW-1:0] nzc_q;

  always @(posedge clk) begin
    ptr_q <= ptr_mem[bus.o_ptr_addr];
    nzv_q <= nzv[bus.o_nz_addr];
    nzc_q <= nzc[bus.o_nz_addr];
    vec_q <= vec[bus.o_vec_addr];
  end

  assign bus.i_ptr_data = ptr_q;
  assign bus.i_nz_val   = nzv_q;
  assign bus.i_nz_col   = nzc_q;
  assign bus.i_vec_data = vec_q;

  // Core: IDLE=0 LOAD=1 MUL=2 ADD=3 WRITE=4; finishes at count==nnz, batch-stops at nonzero multiples of 16
  logic [2:0] cst;
  always @(posedge clk or posedge rst) begin
    if (rst) cst <= 3'd0;
    else case (cst)
      3'd0: if (bus.o_core_start) cst <= 3'd1;
      3'd1: cst <= 3'd2;
      3'd2: cst <= 3'd3;
      3'd3: cst <= 3'd4;
      default:
        if (bus.o_count == bus.o_row_ptr[8*NROW +: 8] ||
            (bus.o_count[3:0] == 4'd0 && bus.o_count != 8'd0)) cst <= 3'd0;
        else cst <= 3'd1;
    endcase
  end
  assign bus.i_core_state = cst;

  int            ld_cnt[$];
  logic [DW-1:0] ld_a[$];
  logic [DW-1:0] ld_b[$];
  int            add_cnt[$];
  logic [CW-1:0] add_col[$];
  int            n_starts = 0;

  always @(negedge clk) begin
    if (cst == 3'd1) begin
      ld_cnt.push_back(int'(bus.o_count));
      ld_a.push_back(bus.o_read_data_A);
      ld_b.push_back(bus.o_read_data_B);
    end
    if (cst == 3'd3) begin
      add_cnt.push_back(int'(bus.o_count));
      add_col.push_back(bus.o_vec_addr);
    end
    if (bus.o_core_start === 1'b1) n_starts++;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fp16_of(input int k);
    int e;
    int m;
    if (k == 0) return 16'h0000;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    m = (k << (10 - e)) & 32'h3FF;
    return {1'b0, 5'(e + 15), 10'(m)};
  endfunction

  // Cycles from the first PTR cycle to the DONE cycle: PTR, 3 prefetch, KICK, 4 per element,
  // plus one idle cycle per batch and one KICK per restart.
  function automatic int exp_lat(input int nnz);
    int b;
    if (nnz == 0) return NROW + 2;
    b = (nnz - 1) / 16 + 1;
    return (NROW + 2) + 3 + 1 + 4 * (nnz + 1) + 2 * b - 1;
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, ".busy"},  w_t'(busy), w_t'(0));
    chk({nm, ".done"},  w_t'(done), w_t'(0));
    chk({nm, ".ptra"},  w_t'(bus.o_ptr_addr), w_t'(0));
    chk({nm, ".nza"},   w_t'(bus.o_nz_addr), w_t'(0));
    chk({nm, ".veca"},  w_t'(bus.o_vec_addr), w_t'(0));
    chk({nm, ".start"}, w_t'(bus.o_core_start), w_t'(0));
    chk({nm, ".A"},     w_t'(bus.o_read_data_A), w_t'(0));
    chk({nm, ".B"},     w_t'(bus.o_read_data_B), w_t'(0));
    chk({nm, ".count"}, w_t'(bus.o_count), w_t'(0));
    chk({nm, ".rowptr"}, w_t'(bus.o_row_ptr), w_t'(0));
  endtask

  task automatic fill_rand(input int nnz);
    for (int i = 0; i < 256; i++) begin
      nzv[i] = 16'($urandom);
      nzc[i] = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < 16; i++) vec[i] = 16'($urandom);
    ptr_mem[0] = 8'd0;
    for (int i = 1; i < NROW; i++) ptr_mem[i] = 8'($urandom_range(int'(ptr_mem[i-1]), nnz));
    ptr_mem[NROW] = 8'(nnz);
    for (int i = NROW + 1; i < 32; i++) ptr_mem[i] = 8'($urandom);
  endtask

  task automatic run_job(input string nm, input int nnz, input bit mid_start, output int lat);
    int b_ld, b_add, s0, n_ld, k;
    logic [8*(NROW+1)-1:0] exp_rp;
    b_ld  = ld_cnt.size();
    b_add = add_cnt.size();
    s0    = n_starts;
    for (int i = 0; i <= NROW; i++) exp_rp[8*i +: 8] = ptr_mem[i];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({nm, ".busy0"}, w_t'(busy), w_t'(1));
    lat = 0;
    while (done !== 1'b1 && lat < LIM) begin
      start = (mid_start && lat == 40);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, ".lat"}, w_t'(lat), w_t'(exp_lat(nnz)));
    chk({nm, ".cnt_done"}, w_t'(bus.o_count), w_t'(nnz == 0 ? 0 : 8'(nnz + 1)));
    chk({nm, ".rp_done"}, w_t'(bus.o_row_ptr), w_t'(exp_rp));
    chk({nm, ".busy_done"}, w_t'(busy), w_t'(1));
    @(negedge clk);
    chk({nm, ".done_1cyc"}, w_t'(done), w_t'(0));
    chk({nm, ".idle"}, w_t'(busy), w_t'(0));
    chk({nm, ".cnt_hold"}, w_t'(bus.o_count), w_t'(nnz == 0 ? 0 : 8'(nnz + 1)));
    chk({nm, ".rp_hold"}, w_t'(bus.o_row_ptr), w_t'(exp_rp));
    chk({nm, ".starts"}, w_t'(n_starts - s0), w_t'(nnz == 0 ? 0 : (nnz - 1) / 16 + 1));
    n_ld = ld_cnt.size() - b_ld;
    chk({nm, ".nload"}, w_t'(n_ld), w_t'(nnz == 0 ? 0 : nnz + 1));
    for (int j = 0; j < n_ld && j <= nnz; j++) begin
      chk($sformatf("%s.cnt[%0d]", nm, j), w_t'(ld_cnt[b_ld + j]), w_t'(j));
      chk($sformatf("%s.A[%0d]", nm, j), w_t'(ld_a[b_ld + j]), w_t'(j < nnz ? nzv[j] : 16'h0));
      chk($sformatf("%s.B[%0d]", nm, j), w_t'(ld_b[b_ld + j]), w_t'(j < nnz ? vec[nzc[j]] : 16'h0));
    end
    for (int j = b_add; j < add_cnt.size(); j++) begin
      k = add_cnt[j];
      if (k + 1 < nnz)
        chk($sformatf("%s.vaddr[%0d]", nm, k + 1), w_t'(add_col[j]), w_t'(nzc[k + 1]));
    end
  endtask

  task automatic setup_diag();
    fill_rand(16);
    for (int i = 0; i <= NROW; i++) ptr_mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) begin
      nzv[i] = 16'h3C00;
      nzc[i] = 4'(i);
      vec[i] = fp16_of(i);
    end
  endtask

  initial begin
    int lat;
    int w;
    bit seen;
    int nnz;

    fill_rand(0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    setup_diag();
    run_job("diag", 16, 1'b0, lat);
    run_job("diag_midstart", 16, 1'b1, lat);

    fill_rand(20);
    for (int i = 0; i <= NROW; i++) ptr_mem[i] = 8'(i < 4 ? 5 * i : 20);
    run_job("batch20", 20, 1'b0, lat);

    fill_rand(0);
    for (int i = 0; i <= NROW; i++) ptr_mem[i] = 8'd0;
    run_job("empty", 0, 1'b0, lat);

    fill_rand(3);
    for (int i = 0; i <= NROW; i++) ptr_mem[i] = 8'(i < 3 ? i : 3);
    nzc[0] = 4'd15; nzc[1] = 4'd0; nzc[2] = 4'd7;
    run_job("cols", 3, 1'b0, lat);

    // Abort a job while the core is in MUL
    setup_diag();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (cst !== 3'd2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("abort.reach_mul", w_t'(cst), w_t'(2));
    #2 rst = 1'b1;
    #1 check_zero("abort");
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort.no_done", w_t'(seen), w_t'(0));
    chk("abort.idle", w_t'(busy), w_t'(0));
    run_job("after_abort", 16, 1'b0, lat);

    repeat (3) begin
      nnz = $urandom_range(1, 60);
      fill_rand(nnz);
      run_job($sformatf("rand%0d", nnz), nnz, 1'b0, lat);
    end

    fill_rand(255);
    run_job("full255", 255, 1'b0, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spmv_feeder.md
Name: spmv_feeder

Overview:
- Supply side of the SpMV core interface: loads the CSR row pointer array, fetches nonzero value, column index and vector element for each element, and drives `i_start`, `count`, `row_ptr`, `i_read_data_A` and `i_read_data_B` of the core.
- Shadows the core's `o_state` so operands are stable whenever the core is in LOAD, and re-kicks the core after each 16-element batch stop until all nonzeros are consumed.
- Sits between three 1-cycle-latency synchronous-read memories (pointer, nonzero, vector) and the core.

Parameters:
- DW, 16, data width of values and vector elements (fp16).
- NROW, 16, matrix rows; the pointer array has NROW+1 entries of 8 bits.
- CW, 4, column index width (vector depth 2^CW).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse; ignored unless in IDLE
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of job
- o_ptr_addr  out  5  pointer memory address
- i_ptr_data  in  8  pointer memory data, valid 1 cycle after address
- o_nz_addr  out  8  nonzero memory address
- i_nz_val  in  DW  nonzero value
- i_nz_col  in  CW  column index
- o_vec_addr  out  CW  vector memory address
- i_vec_data  in  DW  vector element
- i_core_state  in  3  core state (IDLE=0, LOAD=1, MUL=2, ADD=3, WRITE=4)
- o_core_start  out  1  core start pulse
- o_read_data_A  out  DW  nonzero value operand for the core
- o_read_data_B  out  DW  vector operand for the core
- o_count  out  8  current element index (low 8 bits of internal 9-bit counter)
- o_row_ptr  out  8*(NROW+1)  packed pointer array; entry i at bits [8i+:8]

Behaviour:
- Reset: all outputs, internal registers and counter are 0; FSM goes to IDLE. Reset mid-job aborts the job; no o_done is produced.
- FSM states: IDLE, PTR, PRE0, PRE1, PRE2, KICK, RUN, DONE.
- IDLE, on i_start:
  - clear cnt (9 bits) and o_row_ptr;
  - go to PTR.
- PTR: issue o_ptr_addr 0..NROW on consecutive cycles. Data for addr k is written to entry k one cycle later. The state lasts NROW+2 cycles. nnz = entry NROW.
  - If nnz==0, go to DONE (core is never started).
  - Otherwise go to PRE0.
- PRE0: o_nz_addr=cnt.
- PRE1: capture val and col; o_vec_addr=col.
- PRE2: capture vec; load A/B; go to KICK.
- KICK: o_core_start=1 for exactly one cycle; go to RUN.
- RUN, prefetch of element cnt+1 aligned to the core pipeline:
  - core MUL: o_nz_addr=cnt+1.
  - core ADD: capture val/col; o_vec_addr=col.
  - core WRITE: on the clock edge ending WRITE, A<=val, B<=vec, cnt<=cnt+1.
  - A/B therefore never change while the core is in LOAD. o_count holds the element index through LOAD..WRITE, which the core needs for row lookup and finish.
- Prefetch index ≥ nnz: o_read_data_A and o_read_data_B are loaded with 0, so any trailing element the core processes adds exactly 0.
- RUN, core reports IDLE (the core has stopped, either on finish or on a batch boundary at count%16==0):
  - if cnt > nnz, go to DONE;
  - otherwise go to KICK; operands for cnt are already prefetched, so the next batch continues.
- DONE: o_done=1 for one cycle; o_row_ptr and o_count hold their values; return to IDLE.
- Counter width: cnt is 9 bits, so nnz=255 completes without wrap. o_count = cnt[7:0].
- Unused addresses (o_ptr_addr, o_nz_addr, o_vec_addr) hold their last value outside the states that drive them.
- i_start asserted while busy has no effect.

Test Plan:
- row_ptr=0,1,2..16 (diagonal, nnz=16), val=0x3C00, vec[k]=k in fp16 -> exactly one o_core_start; o_count steps 0..16; A/B stable during each core LOAD; o_done one cycle after the core returns to IDLE.
- nnz=20 spread over rows 0..3 -> core stops at count 16; feeder issues a second o_core_start within 1 cycle; o_done only after cnt reaches 21.
- All row_ptr entries 0 (nnz=0) -> no o_core_start; o_done pulses NROW+3 cycles after i_start.
- col index pattern 15,0,7 -> o_vec_addr follows 15,0,7 in the core ADD cycles; B equals vec[15], vec[0], vec[7] in successive LOADs; A/B=0 at element index nnz.
- i_rst asserted during RUN (core in MUL) -> all outputs 0 immediately; no o_done. A new i_start then completes a full job normally.
- i_start pulsed while in RUN -> ignored; the job result and cycle count are unchanged from the no-pulse run.
